// File: rtl/soc_sysid_ext_if.sv
// Avalon-MM bus bundle for the system-ID peripheral.
//   master: drives address/read/write/writedata, receives readdata/readdatavalid
//   slave : the peripheral side of the same signals
interface soc_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/soc_sysid_ext.sv
// System-ID peripheral: build identity, 64-bit uptime counter with prescaler,
// control/status and scratch registers on an Avalon-MM slave.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : Avalon-MM slave (1-cycle read latency, no waitrequest)
//   tick  : one-cycle pulse aligned with each new uptime value
module soc_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1715865134,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned NUM_SCRATCH = 2
) (
  input  logic           clock,
  input  logic           reset,
  soc_sysid_ext_if.slave bus,
  output logic           tick
);

  localparam logic [15:0] DivW  = 16'(TICK_DIV);
  localparam logic [15:0] DivM1 = 16'(TICK_DIV - 1);

  localparam logic [2:0] AddrId     = 3'd0;
  localparam logic [2:0] AddrTstamp = 3'd1;
  localparam logic [2:0] AddrUpLo   = 3'd2;
  localparam logic [2:0] AddrUpHi   = 3'd3;
  localparam logic [2:0] AddrCtrl   = 3'd4;
  localparam logic [2:0] AddrStatus = 3'd5;
  localparam logic [2:0] AddrScr0   = 3'd6;
  localparam logic [2:0] AddrScr1   = 3'd7;

  logic [15:0] pre_q, pre_d;
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        freeze_q, freeze_d;
  logic [31:0] scratch_q [2];
  logic [31:0] scratch_d [2];
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        tick_q, tick_d;

  logic        wr_ctrl;
  logic        clear;
  logic        inc;
  logic [31:0] rmux;

  always_comb begin
    wr_ctrl = bus.write && (bus.address == AddrCtrl);
    clear   = wr_ctrl && bus.writedata[0];
    inc     = !freeze_q && (pre_q == DivM1);

    // Clear takes priority over a same-cycle increment.
    pre_d    = pre_q;
    uptime_d = uptime_q;
    if (clear) begin
      pre_d    = '0;
      uptime_d = '0;
    end else if (!freeze_q) begin
      if (inc) begin
        pre_d    = '0;
        uptime_d = uptime_q + 64'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
    tick_d   = inc && !clear;
    freeze_d = wr_ctrl ? bus.writedata[1] : freeze_q;

    // Slots beyond NUM_SCRATCH stay at zero and ignore writes.
    for (int i = 0; i < 2; i++) begin
      if (i < int'(NUM_SCRATCH)) begin
        scratch_d[i] = (bus.write && (bus.address == 3'(6 + i))) ? bus.writedata
                                                                  : scratch_q[i];
      end else begin
        scratch_d[i] = '0;
      end
    end
  end

  // Read mux sees pre-write/pre-increment state, so same-cycle writes are not visible.
  always_comb begin
    rmux = '0;
    unique case (bus.address)
      AddrId:     rmux = SYSTEM_ID;
      AddrTstamp: rmux = TIMESTAMP;
      AddrUpLo:   rmux = uptime_q[31:0];
      AddrUpHi:   rmux = hi_shadow_q;
      AddrCtrl:   rmux = '0;
      AddrStatus: rmux = {DivW, 15'd0, freeze_q};
      AddrScr0:   rmux = scratch_q[0];
      AddrScr1:   rmux = scratch_q[1];
      default:    rmux = '0;
    endcase
  end

  always_comb begin
    rdata_d     = bus.read ? rmux : rdata_q;
    rvalid_d    = bus.read;
    hi_shadow_d = (bus.read && (bus.address == AddrUpLo)) ? uptime_q[63:32] : hi_shadow_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q        <= '0;
      uptime_q     <= '0;
      hi_shadow_q  <= '0;
      freeze_q     <= 1'b0;
      scratch_q[0] <= '0;
      scratch_q[1] <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      uptime_q     <= uptime_d;
      hi_shadow_q  <= hi_shadow_d;
      freeze_q     <= freeze_d;
      scratch_q[0] <= scratch_d[0];
      scratch_q[1] <= scratch_d[1];
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      tick_q       <= tick_d;
    end
  end

  // A response pending into a reset cycle is suppressed immediately.
  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q && !reset;
  assign tick              = tick_q;

endmodule

// File: tb/tb_soc_sysid_ext.sv
module tb_soc_sysid_ext;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_i  = 1'b1;
  logic        rd_i   = 1'b0;
  logic        wr_i   = 1'b0;
  logic [2:0]  addr_i = '0;
  logic [31:0] wd_i   = '0;

  soc_sysid_ext_if bus1 ();
  soc_sysid_ext_if bus4 ();
  logic tick1, tick4;

  assign bus1.address = addr_i;  assign bus4.address = addr_i;
  assign bus1.read    = rd_i;    assign bus4.read    = rd_i;
  assign bus1.write   = wr_i;    assign bus4.write   = wr_i;
  assign bus1.writedata = wd_i;  assign bus4.writedata = wd_i;

  soc_sysid_ext #(.TICK_DIV(1), .NUM_SCRATCH(2)) u_dut1 (
    .clock (clock), .reset (rst_i), .bus (bus1), .tick (tick1)
  );
  soc_sysid_ext #(.SYSTEM_ID(32'hC0FF_EE01), .TICK_DIV(4), .NUM_SCRATCH(1)) u_dut4 (
    .clock (clock), .reset (rst_i), .bus (bus4), .tick (tick4)
  );

  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        tickv  [2];
  assign rdata[0] = bus1.readdata;  assign rvalid[0] = bus1.readdatavalid;
  assign rdata[1] = bus4.readdata;  assign rvalid[1] = bus4.readdatavalid;
  assign tickv[0] = tick1;          assign tickv[1] = tick4;

  // Reference model: uptime = base + (enabled cycles since clear) / divisor.
  int unsigned     m_div   [2] = '{1, 4};
  int unsigned     m_nscr  [2] = '{2, 1};
  logic [31:0]     m_sysid [2] = '{32'h0000_0000, 32'hC0FF_EE01};
  longint unsigned m_base  [2];
  longint unsigned m_ec    [2];
  logic            m_freeze[2];
  logic [31:0]     m_hi    [2];
  logic [31:0]     m_scr   [2][2];
  logic            exp_valid[2] = '{1'b0, 1'b0};
  logic            exp_tick [2] = '{1'b0, 1'b0};
  logic [31:0]     exp_q0 [$];
  logic [31:0]     exp_q1 [$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [63:0] m_up(input int i);
    return m_base[i] + m_ec[i] / 64'(m_div[i]);
  endfunction

  task automatic push_exp(input int i, input logic [31:0] v);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic m_step(input int i);
    logic [63:0] up;
    logic [31:0] rv;
    logic        clr, inc;
    if (rst_i) begin
      m_base[i] = 0; m_ec[i] = 0; m_freeze[i] = 1'b0; m_hi[i] = '0;
      m_scr[i][0] = '0; m_scr[i][1] = '0;
      exp_valid[i] = 1'b0; exp_tick[i] = 1'b0;
      if (i == 0) exp_q0.delete();
      else        exp_q1.delete();
      return;
    end
    up = m_up(i);
    if (rd_i) begin
      case (addr_i)
        3'd0:    rv = m_sysid[i];
        3'd1:    rv = 32'd1715865134;
        3'd2:    rv = up[31:0];
        3'd3:    rv = m_hi[i];
        3'd5:    rv = {16'(m_div[i]), 15'd0, m_freeze[i]};
        3'd6:    rv = m_scr[i][0];
        3'd7:    rv = m_scr[i][1];
        default: rv = '0;
      endcase
      push_exp(i, rv);
      if (addr_i == 3'd2) m_hi[i] = up[63:32];
    end
    exp_valid[i] = rd_i;
    clr = wr_i && (addr_i == 3'd4) && wd_i[0];
    inc = !m_freeze[i] && ((m_ec[i] % 64'(m_div[i])) == 64'(m_div[i] - 1));
    if (!m_freeze[i]) m_ec[i] = m_ec[i] + 1;
    if (clr) begin
      m_ec[i] = 0; m_base[i] = 0;
    end
    exp_tick[i] = inc && !clr;
    if (wr_i) begin
      if (addr_i == 3'd4) m_freeze[i] = wd_i[1];
      if (addr_i >= 3'd6 && int'(addr_i) - 6 < int'(m_nscr[i])) m_scr[i][addr_i - 3'd6] = wd_i;
    end
  endtask

  initial forever begin
    @(posedge clock);
    m_step(0);
    m_step(1);
  end

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got 0x%08h, expected 0x%08h", name, i, $time, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents read data.
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check("readdatavalid", i, 32'(rvalid[i]), 32'(exp_valid[i] && !rst_i));
      check("tick", i, 32'(tickv[i]), 32'(exp_tick[i]));
      if (rvalid[i] === 1'b1) begin
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
          n_tests++; n_fail++;
          $display("FAIL readdata_unexpected dut%0d at %0t: got 0x%08h, expected none",
                   i, $time, rdata[i]);
        end else if (i == 0) begin
          check("readdata", i, rdata[i], exp_q0.pop_front());
        end else begin
          check("readdata", i, rdata[i], exp_q1.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic rs, input logic r, input logic w, input logic [2:0] a,
                     input logic [31:0] d);
    rst_i = rs; rd_i = r; wr_i = w; addr_i = a; wd_i = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    // Reset, identity reads.
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    rd(3'd0);
    rd(3'd1);
    idle(2);

    // Uptime read ten cycles after reset release.
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    idle(10);
    rd(3'd2);
    rd(3'd3);
    idle(3);

    // Low-word wrap: freeze, preload, unfreeze, read LO in the wrap cycle.
    wr(3'd4, 32'h2);
    idle(1);
    force u_dut1.uptime_q = 64'h0000_0000_FFFF_FFFF;
    force u_dut4.uptime_q = 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < 2; i++) m_base[i] = 64'h0000_0000_FFFF_FFFF - m_ec[i] / 64'(m_div[i]);
    idle(2);
    release u_dut1.uptime_q;
    release u_dut4.uptime_q;
    idle(1);
    wr(3'd4, 32'h0);
    rd(3'd2);
    rd(3'd3);
    idle(2);
    rd(3'd2);
    rd(3'd3);
    idle(2);

    // Clear then freeze; LO stable under freeze, STATUS reflects divisor.
    wr(3'd4, 32'h1);
    idle(12);
    wr(3'd4, 32'h2);
    rd(3'd2);
    idle(3);
    rd(3'd2);
    rd(3'd5);
    rd(3'd4);
    wr(3'd4, 32'h3);
    rd(3'd2);
    wr(3'd4, 32'h0);
    idle(6);

    // Scratch write with same-cycle read, RO write ignored.
    cyc(1'b0, 1'b1, 1'b1, 3'd6, 32'hDEAD_BEEF);
    rd(3'd6);
    cyc(1'b0, 1'b1, 1'b1, 3'd7, 32'h1234_5678);
    rd(3'd7);
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0);
    wr(3'd4, 32'h2);
    idle(1);

    // Read followed by a one-cycle reset: response suppressed.
    rd(3'd6);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    rd(3'd2);
    rd(3'd6);
    rd(3'd4);
    rd(3'd5);
    rd(3'd3);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic        rs, r, w;
      logic [2:0]  a;
      logic [31:0] d;
      rs = ($urandom_range(0, 99) < 2);
      r  = ($urandom_range(0, 1) == 1);
      w  = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd4) d = {30'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1)};
      cyc(rs, r, w, a, d);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
